// File: rtl/por_reset_gen_pkg.sv
// Shared definitions for the power-on reset generator: FSM state encodings,
// default timing constants and the counter-width helper.
package por_reset_gen_pkg;

  typedef enum logic [1:0] {
    WAIT_PG = 2'b00,
    HOLD    = 2'b01,
    RUN     = 2'b10
  } state_e;

  // Defaults assume a 50 MHz clk_in: 20 ms debounce, 1 s hold, 2 s watchdog.
  localparam int DEF_DEB_CYCLES  = 1_000_000;
  localparam int DEF_HOLD_CYCLES = 50_000_000;
  localparam int DEF_WDT_CYCLES  = 100_000_000;

  // A counter over 0..n-1 needs $clog2(n) bits, but never fewer than one.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/por_reset_gen_sync_debounce.sv
// Two-flop synchroniser followed by a debounce filter: the filtered value
// follows the input only after DEB_CYCLES consecutive differing samples.
module sync_debounce
  import por_reset_gen_pkg::*;
#(
  parameter int   DEB_CYCLES = DEF_DEB_CYCLES,
  parameter logic RST_VAL    = 1'b0
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int            DW       = cnt_width(DEB_CYCLES);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          filt_r;
  logic [DW-1:0] deb_cnt_r;

  // Metastability guard for the asynchronous pin.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= RST_VAL;
      sync2_r <= RST_VAL;
    end else begin
      sync1_r <= din;
      sync2_r <= sync1_r;
    end
  end

  // Any sample equal to the filtered value restarts the stability count.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      filt_r    <= RST_VAL;
      deb_cnt_r <= {DW{1'b0}};
    end else if (sync2_r == filt_r) begin
      deb_cnt_r <= {DW{1'b0}};
    end else if (deb_cnt_r == DEB_LAST) begin
      filt_r    <= sync2_r;
      deb_cnt_r <= {DW{1'b0}};
    end else begin
      deb_cnt_r <= deb_cnt_r + DW'(1);
    end
  end

  assign dout = filt_r;

endmodule

// File: rtl/por_reset_gen.sv
// Power-on / manual reset generator: debounced power-good and button feed a
// WAIT_PG/HOLD/RUN sequencer. Optional watchdog enabled by POR_GEN_WDOG_EN.
module por_reset_gen
  import por_reset_gen_pkg::*;
#(
  parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int WDT_CYCLES  = DEF_WDT_CYCLES
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       pg_in,
  input  logic       btn_n,
  input  logic       wdt_kick,
  output logic       rst_out,
  output logic       por_done,
  output logic [7:0] rst_cnt
);

  localparam int            HW        = cnt_width(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  logic          rst_meta_r;
  logic          rst_sync_r;
  logic          pg_f_s;
  logic          btn_f_s;
  logic          wdt_to_s;
  logic          reentry_s;
  state_e        state_r;
  state_e        state_s;
  logic [HW-1:0] hold_cnt_r;
  logic [HW-1:0] hold_cnt_s;
  logic          rst_out_r;
  logic          por_done_r;
  logic [7:0]    rst_cnt_r;

  // Asynchronous assertion, synchronised release of the internal reset.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      rst_meta_r <= 1'b0;
      rst_sync_r <= 1'b0;
    end else begin
      rst_meta_r <= 1'b1;
      rst_sync_r <= rst_meta_r;
    end
  end

  sync_debounce #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b0)) u_pg_deb (
    .clk_in (clk_in),
    .rst_n  (rst_sync_r),
    .din    (pg_in),
    .dout   (pg_f_s)
  );

  sync_debounce #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b0)) u_btn_deb (
    .clk_in (clk_in),
    .rst_n  (rst_sync_r),
    .din    (btn_n),
    .dout   (btn_f_s)
  );

`ifdef POR_GEN_WDOG_EN
  localparam int            WW       = cnt_width(WDT_CYCLES);
  localparam logic [WW-1:0] WDT_LAST = WW'(WDT_CYCLES - 1);

  logic [WW-1:0] wdt_cnt_r;

  // Timeout fires on the last count of an unkicked RUN stretch.
  always_comb begin
    wdt_to_s = 1'b0;
    if ((state_r == RUN) && !wdt_kick && (wdt_cnt_r == WDT_LAST)) begin
      wdt_to_s = 1'b1;
    end else begin
      wdt_to_s = 1'b0;
    end
  end

  // Watchdog counter runs only in RUN; a kick or a timeout clears it.
  always_ff @(posedge clk_in or negedge rst_sync_r) begin
    if (!rst_sync_r) begin
      wdt_cnt_r <= {WW{1'b0}};
    end else if ((state_r != RUN) || wdt_kick || wdt_to_s) begin
      wdt_cnt_r <= {WW{1'b0}};
    end else begin
      wdt_cnt_r <= wdt_cnt_r + WW'(1);
    end
  end
`else
  logic unused_s;
  assign wdt_to_s = 1'b0;
  assign unused_s = wdt_kick ^ (WDT_CYCLES == 0);
`endif

  // Next-state logic; the hold count starts at 1 because the first cycle
  // with power good already counts, keeping release at E+HOLD_CYCLES+1.
  always_comb begin
    state_s    = state_r;
    hold_cnt_s = {HW{1'b0}};
    reentry_s  = 1'b0;
    case (state_r)
      WAIT_PG: begin
        if (btn_f_s && pg_f_s) begin
          if (hold_cnt_r == HOLD_LAST) begin
            state_s = RUN;
          end else begin
            state_s    = HOLD;
            hold_cnt_s = hold_cnt_r + HW'(1);
          end
        end else begin
          state_s = WAIT_PG;
        end
      end
      HOLD: begin
        if (!btn_f_s) begin
          state_s = WAIT_PG;
        end else if (!pg_f_s) begin
          state_s = WAIT_PG;
        end else if (hold_cnt_r == HOLD_LAST) begin
          state_s = RUN;
        end else begin
          state_s    = HOLD;
          hold_cnt_s = hold_cnt_r + HW'(1);
        end
      end
      RUN: begin
        if (!btn_f_s || !pg_f_s || wdt_to_s) begin
          state_s   = WAIT_PG;
          reentry_s = 1'b1;
        end else begin
          state_s = RUN;
        end
      end
      default: begin
        state_s = WAIT_PG;
      end
    endcase
  end

  // State and hold counter registers.
  always_ff @(posedge clk_in or negedge rst_sync_r) begin
    if (!rst_sync_r) begin
      state_r    <= WAIT_PG;
      hold_cnt_r <= {HW{1'b0}};
    end else begin
      state_r    <= state_s;
      hold_cnt_r <= hold_cnt_s;
    end
  end

  // Outputs decoded from the current state so they are glitch-free.
  always_ff @(posedge clk_in or negedge rst_sync_r) begin
    if (!rst_sync_r) begin
      rst_out_r  <= 1'b1;
      por_done_r <= 1'b0;
    end else begin
      rst_out_r  <= (state_r != RUN);
      por_done_r <= (state_r == RUN);
    end
  end

  // Saturating re-entry counter.
  always_ff @(posedge clk_in or negedge rst_sync_r) begin
    if (!rst_sync_r) begin
      rst_cnt_r <= 8'd0;
    end else if (reentry_s && (rst_cnt_r != 8'hFF)) begin
      rst_cnt_r <= rst_cnt_r + 8'd1;
    end else begin
      rst_cnt_r <= rst_cnt_r;
    end
  end

  assign rst_out  = rst_out_r;
  assign por_done = por_done_r;
  assign rst_cnt  = rst_cnt_r;

endmodule
